lcd_char_capture: RTL and testbench
===================================

Name: lcd_char_capture

Overview:
HD44780-style display-side responder for the character-LCD bus that the host LCD controller drives. It samples LCD_DATA/LCD_RS/LCD_RW/LCD_EN, decodes instructions and data writes, and maintains a 2x16 character shadow buffer. It also keeps address-counter, entry-mode and display-control state, and models the busy flag. It sits on the LCD pins, in simulation or on-chip debug, so downstream logic can read back what the host displayed.

Parameters:
BUSY_CYC, 40, busy duration in iCLK cycles after any non-clear instruction or data write
CLEAR_CYC, 64, busy duration after Clear Display; must be >= 32

Ports:
iCLK  in  1  system clock
iRST_N  in  1  synchronous active-low reset
LCD_DATA  in  8  LCD data bus
LCD_RS  in  1  register select: 0 = instruction, 1 = data
LCD_RW  in  1  0 = write, 1 = read
LCD_EN  in  1  enable strobe, asynchronous to iCLK
iRD_ADDR  in  5  buffer readout index: 0-15 = line 1, 16-31 = line 2
oRD_CHAR  out  8  character at iRD_ADDR, registered
oWR_STB  out  1  one-cycle pulse per stored character
oWR_IDX  out  5  buffer index of the stored character
oWR_CHAR  out  8  stored character
oDISP_ON  out  1  display-on bit, D
oBUSY  out  1  modelled busy flag
oAC  out  7  DDRAM address counter
oERR_CNT  out  8  saturating count of transactions dropped while busy

Behaviour:
- Reset applies on the rising edge of iCLK when iRST_N = 0.
  - Buffer is filled with 0x20 over 32 cycles; oBUSY = 1 during the fill.
  - oAC = 0, I/D = 1, oDISP_ON = 0, oBUSY = 1, oERR_CNT = 0, oWR_STB = 0, oWR_IDX = 0, oWR_CHAR = 0, oRD_CHAR = 0.
  - Reset mid-fill or mid-busy restarts the sequence.
- LCD_EN passes through a 2-flop synchronizer.
  - LCD_DATA, LCD_RS and LCD_RW pass through matching 2-stage delays.
  - An EN falling edge is detected on the third register stage.
  - The transaction executes on the next cycle, so state updates 4 iCLK cycles after the EN pin falls.
- A transaction with RW = 1 produces no state change (reads are optional, see below).
- A transaction arriving while oBUSY = 1 is dropped; oERR_CNT increments and saturates at 255.
- Instruction decode (RS = 0), highest set bit wins:
  - 1xxxxxxx Set DDRAM: AC = data[6:0].
  - 01xxxxxx Set CGRAM: ignored, no busy.
  - 001xxxxx Function Set: accepted, no stored effect.
  - 00001DCB Display Control: oDISP_ON = D.
  - 000001IS Entry Mode: I/D = I; S is ignored.
  - 0000001x Return Home: AC = 0.
  - 00000001 Clear:
    - FILL state writes 0x20 to index 0..31, one per cycle.
    - Then AC = 0 and I/D = 1.
    - Busy CLEAR_CYC cycles, counted from execute.
  - 0x00: no-op, no busy.
- Data write (RS = 1):
  - If AC[5:4] = 0 and AC[3:0] in the 16-column window, store to index {AC[6], AC[3:0]}.
  - On a store, pulse oWR_STB with oWR_IDX/oWR_CHAR in the same cycle.
  - Writes outside the window are discarded; AC still steps.
- AC step:
  - I/D = 1: increment; 0x27 -> 0x40, 0x67 -> 0x00.
  - I/D = 0: decrement; 0x40 -> 0x27, 0x00 -> 0x67.
  - Set DDRAM with an out-of-range value (0x28-0x3F, 0x68-0x7F) loads it as-is; the next step wraps as if from the row end.
- Busy: any accepted non-clear instruction (except no-busy cases) or data write sets oBUSY for exactly BUSY_CYC cycles, starting the cycle after execute.
- States: FILL, IDLE, EXEC, BUSY.
  - EXEC -> BUSY, or -> FILL for Clear.
  - FILL -> BUSY until its counter expires.
  - BUSY -> IDLE when the counter reaches 0.
- oRD_CHAR = buffer[iRD_ADDR], 1-cycle latency. If the readout and a write hit the same index in the same cycle, oRD_CHAR shows the old value.

Optional Feature:
LCD_READ_EN:
- Defined: adds outputs oDQ[7:0] and oDQ_OE.
  - While synchronized EN = 1 and RW = 1: oDQ_OE = 1.
    - RS = 0: oDQ = {oBUSY, oAC}.
    - RS = 1: oDQ = the buffer char at AC, or 0x20 when AC is outside the window.
  - A data read steps AC on the EN falling edge and is never dropped.
- Undefined: oDQ/oDQ_OE absent; reads are ignored.

Test Plan:
- Reset, wait 32 + CLEAR_CYC cycles -> all 32 oRD_CHAR reads = 0x20, oBUSY = 0, oAC = 0.
- Instr 0x80, then data 'R','e' (0x52, 0x65) with gaps > BUSY_CYC -> oWR_STB pulses at idx 0 then 1, oAC = 0x02.
- Instr 0xC0, data 0x41 -> idx 16 = 0x41; instr 0x8F, data 0x42, data 0x43 -> idx 15 = 0x42, AC 0x10 out of window, 0x43 discarded, oAC = 0x11.
- Instr 0x04 then 0x80, data 0x44 -> idx 0 = 0x44, oAC = 0x67.
- Data write issued 5 cycles after a prior accepted write -> dropped, oERR_CNT = 1, buffer unchanged.
- With 0x0C issued before Clear: Clear (0x01) with buffer populated -> oBUSY high CLEAR_CYC cycles, all cells 0x20, oAC = 0, oDISP_ON unchanged = 1.

Source files
------------

// File: rtl/lcd_char_capture.sv
// lcd_char_capture
//   HD44780-style display-side responder. Samples the character-LCD bus,
//   decodes instruction/data writes and keeps a 2x16 shadow of the
//   displayed characters plus AC, entry-mode, display-on and busy state.
//
// Parameters
//   BUSY_CYC  : busy cycles after a non-clear instruction or data write
//   CLEAR_CYC : busy cycles after Clear Display (>= 32, covers the fill)
//
// Ports
//   iCLK, iRST_N            : clock, synchronous active-low reset
//   LCD_DATA/RS/RW/EN       : LCD bus pins (EN asynchronous to iCLK)
//   iRD_ADDR / oRD_CHAR     : buffer readout, 1-cycle latency
//   oWR_STB/oWR_IDX/oWR_CHAR: one-cycle pulse per stored character
//   oDISP_ON, oBUSY, oAC    : display-on bit, busy flag, address counter
//   oERR_CNT                : saturating count of writes dropped while busy
//   oDQ / oDQ_OE            : read-back bus, only with LCD_READ_EN defined
//
// Optional feature macro: LCD_READ_EN (bus reads: status and data read).
module lcd_char_capture #(
  parameter int BUSY_CYC  = 40,
  parameter int CLEAR_CYC = 64
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] LCD_DATA,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic [4:0] iRD_ADDR,
  output logic [7:0] oRD_CHAR,
  output logic       oWR_STB,
  output logic [4:0] oWR_IDX,
  output logic [7:0] oWR_CHAR,
  output logic       oDISP_ON,
  output logic       oBUSY,
  output logic [6:0] oAC,
`ifdef LCD_READ_EN
  output logic [7:0] oDQ,
  output logic       oDQ_OE,
`endif
  output logic [7:0] oERR_CNT
);

  localparam int CMAX = (BUSY_CYC > CLEAR_CYC) ? BUSY_CYC : CLEAR_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] BUSY_LD = CW'(BUSY_CYC - 1);
  // The 32-cycle fill is part of the clear busy time; the tail covers the rest.
  localparam bit            CLR_TAIL = (CLEAR_CYC > 32);
  localparam logic [CW-1:0] CLR_LD   = CLR_TAIL ? CW'(CLEAR_CYC - 33) : '0;

  typedef enum logic [1:0] {FILL, IDLE, EXEC, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    fill_q, fill_d;
  logic [6:0]    ac_q, ac_d;
  logic          id_q, id_d;
  logic          disp_q, disp_d;
  logic [7:0]    err_q, err_d;
  logic [7:0]    tdat_q, tdat_d;
  logic          trs_q, trs_d;
  logic          stb_q, stb_d;
  logic [4:0]    widx_q, widx_d;
  logic [7:0]    wchr_q, wchr_d;
  logic [7:0]    rd_q;

  logic [2:0]    en_q;
  logic [7:0]    dat1_q, dat2_q;
  logic [1:0]    rs_q, rw_q;

  logic [7:0]    buf_q [32];
  logic          mem_we;
  logic [4:0]    mem_wa;
  logic [7:0]    mem_wd;

  logic          fall, wr_txn;

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] r;
    if (inc) begin
      // Anything at or past the row end (including out-of-range loads) wraps.
      if (ac[5:0] >= 6'h27) r = ac[6] ? 7'h00 : 7'h40;
      else                  r = ac + 7'd1;
    end else begin
      if (ac[5:0] == 6'h00)     r = ac[6] ? 7'h27 : 7'h67;
      else if (ac[5:0] > 6'h27) r = {ac[6], 6'h26};
      else                      r = ac - 7'd1;
    end
    return r;
  endfunction

  // Bus synchronizer: EN through 3 stages, RS/RW/DATA delayed to line up
  // with the second EN stage so they are stable when the fall is seen.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      en_q   <= '0;
      dat1_q <= '0;
      dat2_q <= '0;
      rs_q   <= '0;
      rw_q   <= '0;
    end else begin
      en_q   <= {en_q[1:0], LCD_EN};
      dat1_q <= LCD_DATA;
      dat2_q <= dat1_q;
      rs_q   <= {rs_q[0], LCD_RS};
      rw_q   <= {rw_q[0], LCD_RW};
    end
  end

  assign fall   = en_q[2] & ~en_q[1];
  assign wr_txn = fall & ~rw_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    ac_d    = ac_q;
    id_d    = id_q;
    disp_d  = disp_q;
    err_d   = err_q;
    tdat_d  = tdat_q;
    trs_d   = trs_q;
    stb_d   = 1'b0;
    widx_d  = widx_q;
    wchr_d  = wchr_q;
    mem_we  = 1'b0;
    mem_wa  = '0;
    mem_wd  = '0;

    if (wr_txn && state_q != IDLE && err_q != 8'hFF) err_d = err_q + 8'd1;

`ifdef LCD_READ_EN
    if (fall && rw_q[1] && rs_q[1]) ac_d = ac_step(ac_q, id_q);
`endif

    case (state_q)
      FILL: begin
        mem_we = 1'b1;
        mem_wa = fill_q;
        mem_wd = 8'h20;
        fill_d = fill_q + 5'd1;
        if (fill_q == 5'd31) begin
          ac_d = '0;
          id_d = 1'b1;
          if (CLR_TAIL) begin
            state_d = BUSY;
            cnt_d   = CLR_LD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        if (wr_txn) begin
          tdat_d  = dat2_q;
          trs_d   = rs_q[1];
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = BUSY;
        cnt_d   = BUSY_LD;
        if (trs_q) begin
          if (ac_q[5:4] == 2'b00) begin
            mem_we = 1'b1;
            mem_wa = {ac_q[6], ac_q[3:0]};
            mem_wd = tdat_q;
            stb_d  = 1'b1;
            widx_d = {ac_q[6], ac_q[3:0]};
            wchr_d = tdat_q;
          end
          ac_d = ac_step(ac_q, id_q);
        end else begin
          casez (tdat_q)
            8'b1???????: ac_d = tdat_q[6:0];
            8'b01??????: state_d = IDLE;
            8'b001?????: ;
            8'b00001???: disp_d = tdat_q[2];
            8'b000001??: id_d = tdat_q[1];
            8'b0000001?: ac_d = '0;
            8'b00000001: begin
              state_d = FILL;
              fill_d  = '0;
            end
            default:     state_d = IDLE;
          endcase
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= FILL;
      cnt_q   <= '0;
      fill_q  <= '0;
      ac_q    <= '0;
      id_q    <= 1'b1;
      disp_q  <= 1'b0;
      err_q   <= '0;
      tdat_q  <= '0;
      trs_q   <= 1'b0;
      stb_q   <= 1'b0;
      widx_q  <= '0;
      wchr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      ac_q    <= ac_d;
      id_q    <= id_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      tdat_q  <= tdat_d;
      trs_q   <= trs_d;
      stb_q   <= stb_d;
      widx_q  <= widx_d;
      wchr_q  <= wchr_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (mem_we) buf_q[mem_wa] <= mem_wd;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) rd_q <= '0;
    else         rd_q <= buf_q[iRD_ADDR];
  end

  assign oRD_CHAR = rd_q;
  assign oWR_STB  = stb_q;
  assign oWR_IDX  = widx_q;
  assign oWR_CHAR = wchr_q;
  assign oDISP_ON = disp_q;
  assign oBUSY    = (state_q == FILL) || (state_q == BUSY);
  assign oAC      = ac_q;
  assign oERR_CNT = err_q;

`ifdef LCD_READ_EN
  logic [7:0] ac_char;
  assign ac_char = (ac_q[5:4] == 2'b00) ? buf_q[{ac_q[6], ac_q[3:0]}] : 8'h20;
  assign oDQ_OE  = en_q[1] & rw_q[1];
  assign oDQ     = rs_q[1] ? ac_char : {oBUSY, ac_q};
`endif

endmodule

// File: tb/tb_lcd_char_capture.sv
// Directed self-checking bench for lcd_char_capture (default build).
module tb_lcd_char_capture;

  localparam int BUSY_CYC  = 40;
  localparam int CLEAR_CYC = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] lcd_data = '0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_en = 1'b0;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_char;
  logic       wr_stb;
  logic [4:0] wr_idx;
  logic [7:0] wr_char;
  logic       disp_on;
  logic       busy;
  logic [6:0] ac;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;
  int stb_n = 0;
  logic [4:0] stb_idx = '0;
  logic [7:0] stb_chr = '0;

  lcd_char_capture #(.BUSY_CYC(BUSY_CYC), .CLEAR_CYC(CLEAR_CYC)) dut (
    .iCLK(clk), .iRST_N(rst_n),
    .LCD_DATA(lcd_data), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_EN(lcd_en),
    .iRD_ADDR(rd_addr), .oRD_CHAR(rd_char),
    .oWR_STB(wr_stb), .oWR_IDX(wr_idx), .oWR_CHAR(wr_char),
    .oDISP_ON(disp_on), .oBUSY(busy), .oAC(ac), .oERR_CNT(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      stb_n++;
      stb_idx = wr_idx;
      stb_chr = wr_char;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full bus write; returns on the 4th falling clock edge after EN drops.
  task automatic lcd_wr(input logic rs, input logic [7:0] d);
    lcd_rs = rs;
    lcd_rw = 1'b0;
    lcd_data = d;
    repeat (2) @(negedge clk);
    lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    lcd_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] v);
    rd_addr = a;
    @(negedge clk);
    v = rd_char;
  endtask

  initial begin
    int n;
    logic [7:0] v;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_ac", ac, 0);
    chk("rst_disp", disp_on, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_stb", wr_stb, 0);
    chk("rst_idx", wr_idx, 0);
    chk("rst_chr", wr_char, 0);
    chk("rst_rd", rd_char, 0);
    rst_n = 1'b1;
    wait_busy(n);
    chk("rst_busy_len", n, CLEAR_CYC);
    chk("post_rst_ac", ac, 0);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), v);
      chk($sformatf("fill_%0d", i), v, 8'h20);
    end

    lcd_wr(0, 8'h80); wait_busy(n);
    chk("busy_len_instr", n, BUSY_CYC);
    lcd_wr(1, 8'h52); wait_busy(n);
    chk("busy_len_data", n, BUSY_CYC);
    chk("stb1_n", stb_n, 1);
    chk("stb1_idx", stb_idx, 0);
    chk("stb1_chr", stb_chr, 8'h52);
    lcd_wr(1, 8'h65); wait_busy(n);
    chk("stb2_n", stb_n, 2);
    chk("stb2_idx", stb_idx, 1);
    chk("stb2_chr", stb_chr, 8'h65);
    chk("ac_after_re", ac, 7'h02);

    lcd_wr(0, 8'hC0); wait_busy(n);
    chk("ac_line2", ac, 7'h40);
    lcd_wr(1, 8'h41); wait_busy(n);
    chk("stb3_idx", stb_idx, 16);
    lcd_wr(0, 8'h8F); wait_busy(n);
    lcd_wr(1, 8'h42); wait_busy(n);
    chk("stb4_idx", stb_idx, 15);
    chk("ac_0x10", ac, 7'h10);
    lcd_wr(1, 8'h43); wait_busy(n);
    chk("outwin_nostb", stb_n, 4);
    chk("outwin_ac", ac, 7'h11);
    rd(5'd15, v); chk("buf15", v, 8'h42);
    rd(5'd16, v); chk("buf16", v, 8'h41);
    rd(5'd1, v);  chk("buf1", v, 8'h65);

    lcd_wr(0, 8'h04); wait_busy(n);
    lcd_wr(0, 8'h80); wait_busy(n);
    lcd_wr(1, 8'h44); wait_busy(n);
    chk("stb5_idx", stb_idx, 0);
    chk("dec_wrap_ac", ac, 7'h67);
    rd(5'd0, v); chk("buf0_44", v, 8'h44);

    lcd_wr(0, 8'h00); wait_busy(n);
    chk("nop_nobusy", n, 0);
    lcd_wr(0, 8'h40); wait_busy(n);
    chk("cgram_nobusy", n, 0);
    chk("cgram_ac", ac, 7'h67);

    lcd_wr(0, 8'h06); wait_busy(n);
    lcd_wr(0, 8'hA7); wait_busy(n);
    chk("ac_0x27", ac, 7'h27);
    lcd_wr(1, 8'h30); wait_busy(n);
    chk("inc_wrap_ac", ac, 7'h40);
    chk("inc_wrap_nostb", stb_n, 5);

    lcd_wr(0, 8'h81); wait_busy(n);
    lcd_wr(1, 8'h58);
    lcd_wr(1, 8'h59);
    wait_busy(n);
    chk("drop_err", err_cnt, 1);
    chk("drop_ac", ac, 7'h02);
    chk("drop_stb_n", stb_n, 6);
    rd(5'd1, v); chk("buf1_58", v, 8'h58);
    rd(5'd2, v); chk("buf2_untouched", v, 8'h20);

    lcd_wr(0, 8'h0C); wait_busy(n);
    chk("disp_on", disp_on, 1);
    lcd_wr(0, 8'h04); wait_busy(n);
    lcd_wr(0, 8'h01); wait_busy(n);
    chk("clear_busy_len", n, CLEAR_CYC);
    chk("clear_ac", ac, 0);
    chk("clear_disp_kept", disp_on, 1);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), v);
      chk($sformatf("clr_%0d", i), v, 8'h20);
    end
    lcd_wr(1, 8'h5A); wait_busy(n);
    chk("post_clr_idx", stb_idx, 0);
    chk("post_clr_chr", stb_chr, 8'h5A);
    chk("post_clr_ac_inc", ac, 7'h01);
    chk("post_clr_err", err_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
